// File: rtl/noc_host_rx.sv
// Host-side ejection interface: filters packets by destination, buffers good
// ones in a first-word-fall-through FIFO and counts drops and deliveries.
module noc_host_rx #(
    parameter int PACKET_SIZE = 8,
    parameter int NUM_ROUTERS = 4,
    parameter int ROUTER_ID   = 0,
    parameter int DEPTH       = 4,
    localparam int ID_W       = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1,
    localparam int PAYLOAD_W  = PACKET_SIZE - 2 * ID_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PACKET_SIZE-1:0] host_data_out,
    input  logic                   host_out_valid,
    output logic                   host_out_ready,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [ID_W-1:0]        rx_src,
    output logic [PAYLOAD_W-1:0]   rx_payload,
    output logic [7:0]             drop_cnt,
    output logic [15:0]            pkt_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENTRY_W = PACKET_SIZE - ID_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [ID_W-1:0] LOCAL_ID = ID_W'(ROUTER_ID);

    // The destination field is consumed by the filter, so only src and payload are stored.
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     count;

    logic accept;
    logic good;
    logic drop;
    logic pop;

    assign host_out_ready = (count != FULL_COUNT) && !rst;
    assign rx_valid       = (count != '0) && !rst;

    assign accept = host_out_valid && host_out_ready;
    assign good   = accept && (host_data_out[ID_W-1:0] == LOCAL_ID);
    assign drop   = accept && (host_data_out[ID_W-1:0] != LOCAL_ID);
    assign pop    = rx_valid && rx_ready;

    assign rx_src     = mem[rd_ptr][ID_W-1:0];
    assign rx_payload = mem[rd_ptr][ENTRY_W-1:ID_W];

    always_ff @(posedge clk) begin
        if (good) begin
            mem[wr_ptr] <= host_data_out[PACKET_SIZE-1:ID_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (good) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({good, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            pkt_cnt  <= '0;
        end else begin
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (pop) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule
